// File: rtl/led_mode_ctrl.sv
// Front-panel button controller: synchronises and debounces the mode and
// frequency buttons and steps or restores the LED pattern selections.

module led_btn_fsm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter bit HAS_LONG        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic step,
  output logic clear
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    WAIT_REL,
    DEB_REL
  } state_t;

  state_t          state, state_nxt, ret, ret_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt, hcnt_inc;
  logic            accept, short_ev, long_ev;

  assign hcnt_inc = (hcnt == H_MAX) ? hcnt : hcnt + HW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ret   <= PRESSED;
      dcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      dcnt  <= dcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    dcnt_nxt  = dcnt;
    hcnt_nxt  = hcnt;
    accept    = 1'b0;
    short_ev  = 1'b0;
    long_ev   = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = DEB_PRESS;
          dcnt_nxt  = D_ONE;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt >= D_LAST) begin
          state_nxt = PRESSED;
          dcnt_nxt  = '0;
          hcnt_nxt  = '0;
          accept    = 1'b1;
        end else begin
          dcnt_nxt  = dcnt + D_ONE;
        end
      end
      PRESSED: begin
        if (HAS_LONG && hcnt >= H_LAST) begin
          state_nxt = WAIT_REL;
          hcnt_nxt  = H_MAX;
          long_ev   = 1'b1;
        end else if (!s) begin
          state_nxt = DEB_REL;
          ret_nxt   = PRESSED;
          dcnt_nxt  = D_ONE;
          hcnt_nxt  = hcnt_inc;
        end else begin
          hcnt_nxt  = hcnt_inc;
        end
      end
      WAIT_REL: begin
        if (!s) begin
          state_nxt = DEB_REL;
          ret_nxt   = WAIT_REL;
          dcnt_nxt  = D_ONE;
        end
      end
      DEB_REL: begin
        // Hold time keeps running through a release glitch so a bouncy
        // long press still fires on schedule.
        if (ret == PRESSED) hcnt_nxt = hcnt_inc;
        if (s) begin
          state_nxt = ret;
          dcnt_nxt  = '0;
        end else if (dcnt >= D_LAST) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
          short_ev  = (ret == PRESSED);
        end else begin
          dcnt_nxt  = dcnt + D_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  assign step  = HAS_LONG ? short_ev : accept;
  assign clear = long_ev;

endmodule

module led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_freq,
  output logic [1:0] mode_sel,
  output logic [1:0] freq_sel,
  output logic       mode_pulse,
  output logic       freq_pulse
);

  logic [1:0] mode_sync, freq_sync;
  logic       mode_step, mode_clear, freq_step, freq_clear, clear_all;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync <= '0;
      freq_sync <= '0;
    end else begin
      mode_sync <= {mode_sync[0], btn_mode};
      freq_sync <= {freq_sync[0], btn_freq};
    end
  end

  led_btn_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .HAS_LONG        (1'b1)
  ) u_mode_fsm (
    .clk   (clk),
    .reset (reset),
    .s     (mode_sync[1]),
    .step  (mode_step),
    .clear (mode_clear)
  );

  led_btn_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .HAS_LONG        (1'b0)
  ) u_freq_fsm (
    .clk   (clk),
    .reset (reset),
    .s     (freq_sync[1]),
    .step  (freq_step),
    .clear (freq_clear)
  );

  // A restore wins over a same-cycle frequency step and yields a single pulse.
  assign clear_all = mode_clear | freq_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sel   <= '0;
      freq_sel   <= '0;
      mode_pulse <= 1'b0;
      freq_pulse <= 1'b0;
    end else begin
      mode_pulse <= mode_step | clear_all;
      freq_pulse <= freq_step | clear_all;
      if (clear_all) begin
        mode_sel <= '0;
        freq_sel <= '0;
      end else begin
        if (mode_step) mode_sel <= mode_sel + 2'd1;
        if (freq_step) freq_sel <= freq_sel + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl: stimulus pushes expected select updates
// into a scoreboard; a monitor compares outputs every cycle on the falling edge.

module tb_led_mode_ctrl;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [1:0] freq;
    logic       mp;
    logic       fp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_freq;
  logic [1:0] mode_sel, freq_sel;
  logic       mode_pulse, freq_pulse;

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  bit         done = 1'b0;
  exp_t       sb[$];
  exp_t       e;
  logic [1:0] exp_mode = 2'd0, exp_freq = 2'd0;
  logic       exp_mp, exp_fp;
  logic [1:0] mdl_mode = 2'd0, mdl_freq = 2'd0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_freq   (btn_freq),
    .mode_sel   (mode_sel),
    .freq_sel   (freq_sel),
    .mode_pulse (mode_pulse),
    .freq_pulse (freq_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, expv);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      exp_mode = 2'd0;
      exp_freq = 2'd0;
    end
    exp_mp = 1'b0;
    exp_fp = 1'b0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e        = sb.pop_front();
      exp_mode = e.mode;
      exp_freq = e.freq;
      exp_mp   = e.mp;
      exp_fp   = e.fp;
    end
    check("mode_sel", mode_sel, exp_mode);
    check("freq_sel", freq_sel, exp_freq);
    check("mode_pulse", {1'b0, mode_pulse}, {1'b0, exp_mp});
    check("freq_pulse", {1'b0, freq_pulse}, {1'b0, exp_fp});
    if (done || cyc > 5000) begin
      checks++;
      assert (done && sb.size() == 0) passes++;
      else $error("FAIL sb_drain: done=%0d pending=%0d expected done=1 pending=0", done, sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [1:0] m, input logic [1:0] f,
                         input logic mp, input logic fp);
    exp_t x;
    x.cyc  = c;
    x.mode = m;
    x.freq = f;
    x.mp   = mp;
    x.fp   = fp;
    sb.push_back(x);
  endtask

  task automatic freq_press();
    push_ev(cyc + 6, mdl_mode, mdl_freq + 2'd1, 1'b0, 1'b1);
    mdl_freq = mdl_freq + 2'd1;
    btn_freq = 1'b1;
    tick(10);
    btn_freq = 1'b0;
    tick(10);
  endtask

  task automatic mode_press();
    btn_mode = 1'b1;
    tick(8);
    btn_mode = 1'b0;
    push_ev(cyc + 6, mdl_mode + 2'd1, mdl_freq, 1'b1, 1'b0);
    mdl_mode = mdl_mode + 2'd1;
    tick(12);
  endtask

  task automatic bounce4();
    btn_freq = 1'b1; tick(3);
    btn_freq = 1'b0; tick(1);
    btn_freq = 1'b1; tick(3);
    btn_freq = 1'b0; tick(1);
  endtask

  task automatic long_press(input bit with_freq);
    push_ev(cyc + 22, 2'd0, 2'd0, 1'b1, 1'b1);
    mdl_mode = 2'd0;
    mdl_freq = 2'd0;
    btn_mode = 1'b1; tick(12);
    btn_mode = 1'b0; tick(2);
    btn_mode = 1'b1;
    if (with_freq) begin
      tick(2);
      btn_freq = 1'b1; tick(10);
      btn_freq = 1'b0; tick(14);
    end else begin
      tick(26);
    end
    btn_mode = 1'b0;
    tick(20);
  endtask

  initial begin
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_freq = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      btn_freq = (i % 3) == 0;
      tick(1);
    end
    btn_mode = 1'b0;
    btn_freq = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(50);

    for (int i = 0; i < 4; i++) freq_press();

    bounce4();
    tick(12);
    bounce4();
    push_ev(cyc + 6, mdl_mode, mdl_freq + 2'd1, 1'b0, 1'b1);
    mdl_freq = mdl_freq + 2'd1;
    btn_freq = 1'b1; tick(8);
    btn_freq = 1'b0; tick(12);

    for (int i = 0; i < 4; i++) mode_press();

    btn_mode = 1'b1; tick(8);
    btn_mode = 1'b0;
    btn_freq = 1'b1;
    push_ev(cyc + 6, mdl_mode + 2'd1, mdl_freq + 2'd1, 1'b1, 1'b1);
    mdl_mode = mdl_mode + 2'd1;
    mdl_freq = mdl_freq + 2'd1;
    tick(10);
    btn_freq = 1'b0;
    tick(12);

    while (mdl_mode != 2'd2) mode_press();
    while (mdl_freq != 2'd3) freq_press();
    long_press(1'b0);

    freq_press();
    long_press(1'b1);

    mode_press();
    freq_press();
    btn_freq = 1'b1;
    tick(4);
    reset    = 1'b0;
    mdl_mode = 2'd0;
    mdl_freq = 2'd0;
    tick(2);
    reset = 1'b1;
    push_ev(cyc + 6, 2'd0, 2'd1, 1'b0, 1'b1);
    mdl_freq = 2'd1;
    tick(10);
    btn_freq = 1'b0;
    tick(15);

    done = 1'b1;
  end

endmodule
